// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch/flush logic.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LEN0  = 3'd2,
        S_LEN1  = 3'd3,
        S_DATA  = 3'd4,
        S_FIN   = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD = 32'h00000013;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Four-byte little-endian word assembler; o_word_valid fires on the cycle the 4th byte is accepted.
module imem_loader_byte_packer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    logic [23:0] r_buf;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 2'd0;
            r_buf <= 24'd0;
        end else if (i_clr) begin
            r_cnt <= 2'd0;
        end else if (i_accept) begin
            case (r_cnt)
                2'd0:    r_buf[7:0]   <= i_byte;
                2'd1:    r_buf[15:8]  <= i_byte;
                2'd2:    r_buf[23:16] <= i_byte;
                default: ;
            endcase
            r_cnt <= r_cnt + 2'd1;
        end
    end

    assign o_word_valid = i_accept & ~i_clr & (r_cnt == 2'd3);
    assign o_word       = {i_byte, r_buf};

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a byte stream: NOP clear, 16-bit word count, then LE words.
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] NOP_WORD   = imem_loader_pkg::NOP_WORD
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_s_valid,
    input  logic [7:0]  i_s_data,
    output logic        o_s_ready,
    output logic        o_wr_en,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic        o_cpu_hold,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_word_count
);
    import imem_loader_pkg::*;

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_clr_idx;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_len;
    logic                  r_wr_en, r_cpu_hold, r_done, r_err;
    logic [31:0]           r_wr_addr, r_wr_data;
    logic [15:0]           r_word_count;

    logic        w_abort, w_s_ready, w_accept, w_len_bad, w_last_word;
    logic        w_pk_valid;
    logic [31:0] w_pk_word;
    logic [15:0] w_len;

    assign w_abort     = i_abort & (r_state != S_IDLE);
    assign w_s_ready   = (r_state == S_LEN0) | (r_state == S_LEN1) | (r_state == S_DATA);
    // abort wins over a byte offered in the same cycle
    assign w_accept    = i_s_valid & w_s_ready & ~w_abort;
    assign w_len       = {i_s_data, r_len_lo};
    assign w_len_bad   = (w_len == 16'd0) | ({1'b0, w_len} > DEPTH);
    assign w_last_word = w_pk_valid & ((r_word_count + 16'd1) == r_len);

    imem_loader_byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clr        ((r_state != S_DATA) | w_abort),
        .i_accept     (w_accept & (r_state == S_DATA)),
        .i_byte       (i_s_data),
        .o_word_valid (w_pk_valid),
        .o_word       (w_pk_word)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_start) w_next = S_CLEAR;
                S_CLEAR: if (&r_clr_idx) w_next = S_LEN0;
                S_LEN0:  if (w_accept) w_next = S_LEN1;
                S_LEN1:  if (w_accept) w_next = w_len_bad ? S_ERR : S_DATA;
                S_DATA:  if (w_last_word) w_next = S_FIN;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clr_idx    <= '0;
            r_len_lo     <= 8'd0;
            r_len        <= 16'd0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 32'd0;
            r_wr_data    <= 32'd0;
            r_cpu_hold   <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= 16'd0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            if (w_abort) begin
                r_err      <= 1'b1;
                r_cpu_hold <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (i_start) begin
                        r_err        <= 1'b0;
                        r_word_count <= 16'd0;
                        r_cpu_hold   <= 1'b1;
                        r_clr_idx    <= '0;
                    end
                    S_CLEAR: begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= 32'({r_clr_idx, 2'b00});
                        r_wr_data <= NOP_WORD;
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                    S_LEN0: if (w_accept) r_len_lo <= i_s_data;
                    S_LEN1: if (w_accept) r_len <= w_len;
                    S_DATA: if (w_pk_valid) begin
                        r_wr_en      <= 1'b1;
                        r_wr_addr    <= 32'({r_word_count[ADDR_WIDTH-1:0], 2'b00});
                        r_wr_data    <= w_pk_word;
                        r_word_count <= r_word_count + 16'd1;
                    end
                    S_FIN: begin
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end
                    S_ERR: begin
                        r_err      <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_s_ready    = w_s_ready;
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_cpu_hold   = r_cpu_hold;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_word_count = r_word_count;

endmodule
